// File: rtl/jtcps1_fbwr_if.sv
// Frame-buffer write bus between jtcps1_fbwr and the external frame buffer.
//   line_data  pixel to store
//   line_addr  column (x) of line_data
//   line_row   row (y) of line_data
//   line_wr    write request, held until line_wr_ok
//   line_wr_ok frame buffer takes the write on this clock
// master: the writer (jtcps1_fbwr). slave: the frame buffer side.
interface jtcps1_fbwr_if #(
  parameter int DW = 12
);
  logic [DW-1:0] line_data;
  logic [8:0]    line_addr;
  logic [8:0]    line_row;
  logic          line_wr;
  logic          line_wr_ok;

  modport master (
    output line_data, line_addr, line_row, line_wr,
    input  line_wr_ok
  );

  modport slave (
    input  line_data, line_addr, line_row, line_wr,
    output line_wr_ok
  );
endinterface

// File: rtl/jtcps1_fbwr.sv
// jtcps1_fbwr: frame-buffer writer fed by the colour mixer.
// Each visible pixel (pxl_cen & ~HB & ~VB) is tagged with {vdump, col} and
// queued in a DEPTH-entry FIFO, then drained to the frame buffer through the
// line_wr/line_wr_ok handshake so SDRAM latency never stalls the video.
//
// Ports
//   clk, rstn         clock, synchronous active-low reset
//   pxl_cen, HB, VB   pixel enable and blanking from the video timing
//   vdump             current scan line, stored as the row of each pixel
//   pxl_data          colmix pixel
//   fb_en             frame enable, only looked at on the VB falling edge
//   fb                frame-buffer write bus (master side)
//   frame_done        one-cycle pulse once the whole frame is written
//   overflow          sticky, a pixel was dropped during this frame
//   drop_cnt          dropped pixels this frame, saturating
//                     (only with JTCPS1_FBWR_DROPCNT_EN defined)
//
// Build option: define JTCPS1_FBWR_DROPCNT_EN to add the drop_cnt port.
module jtcps1_fbwr #(
  parameter int DEPTH = 16,
  parameter int DW    = 12
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          pxl_cen,
  input  logic          HB,
  input  logic          VB,
  input  logic [8:0]    vdump,
  input  logic [DW-1:0] pxl_data,
  input  logic          fb_en,
  jtcps1_fbwr_if.master fb,
  output logic          frame_done,
  output logic          overflow
`ifdef JTCPS1_FBWR_DROPCNT_EN
  ,
  output logic [15:0]   drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef struct packed {
    logic [8:0]    row;
    logic [8:0]    col;
    logic [DW-1:0] data;
  } ent_t;

  typedef enum logic [1:0] {WAIT_VB, ACTIVE, FLUSH, DONE} state_t;

  state_t        st, st_nx;
  logic          vb_l, vb_fall, vb_rise, enter_act;
  logic [8:0]    col;

  ent_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          empty, full;
  logic          push_try, push_ok, drop;
  logic          accept, load_idle, more;
  ent_t          head, nxt, load_ent;

  // ---------------------------------------------------------------- FSM
  assign vb_fall = vb_l & ~VB;
  assign vb_rise = ~vb_l & VB;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      st   <= WAIT_VB;
      vb_l <= 1'b0;     // VB must be seen high before a falling edge counts
    end else begin
      st   <= st_nx;
      vb_l <= VB;
    end
  end

  always_comb begin
    st_nx     = st;
    enter_act = 1'b0;
    case (st)
      WAIT_VB: if (vb_fall && fb_en) begin
        st_nx     = ACTIVE;
        enter_act = 1'b1;
      end
      ACTIVE:  if (vb_rise) st_nx = FLUSH;
      // The head stays in the FIFO until accepted, so empty alone would be
      // enough; line_wr is checked too so no write is ever left in flight.
      FLUSH:   if (empty && !fb.line_wr) st_nx = DONE;
      DONE:    st_nx = WAIT_VB;
      default: st_nx = WAIT_VB;
    endcase
  end

  assign frame_done = (st == DONE);

  // ---------------------------------------------------------- push side
  assign push_try = (st == ACTIVE) & pxl_cen & ~HB & ~VB;
  assign empty    = (count == '0);
  // Full is judged before any pop on the same edge: a pixel arriving on the
  // edge that frees a slot is still dropped.
  assign full     = (count == CNT_FULL);
  assign push_ok  = push_try & ~full;
  assign drop     = push_try & full;

  // Column advances on every attempt so pixels after a drop keep their x.
  always_ff @(posedge clk) begin
    if (!rstn)         col <= '0;
    else if (HB)       col <= '0;
    else if (push_try) col <= col + 9'd1;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= '{row: vdump, col: col, data: pxl_data};
  end

  // --------------------------------------------------------- drain side
  // The entry shown on the bus remains the FIFO head until accepted, so it
  // still occupies a slot. Popping happens only on acceptance.
  assign accept    = fb.line_wr & fb.line_wr_ok;
  assign load_idle = ~fb.line_wr & ~empty;
  assign more      = (count > CNT_ONE);
  assign head      = mem[rd_ptr];
  assign nxt       = mem[rd_ptr + PTR_ONE];
  assign load_ent  = fb.line_wr ? nxt : head;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (accept)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, accept})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Output register: loads when idle, or right on acceptance when the next
  // entry is already stored (back-to-back writes). Holds during a stall.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      fb.line_wr   <= 1'b0;
      fb.line_data <= '0;
      fb.line_addr <= '0;
      fb.line_row  <= '0;
    end else if (load_idle || (accept && more)) begin
      fb.line_wr   <= 1'b1;
      fb.line_data <= load_ent.data;
      fb.line_addr <= load_ent.col;
      fb.line_row  <= load_ent.row;
    end else if (accept) begin
      fb.line_wr   <= 1'b0;
    end
  end

  // ------------------------------------------------------ drop reporting
  always_ff @(posedge clk) begin
    if (!rstn)          overflow <= 1'b0;
    else if (enter_act) overflow <= 1'b0;
    else if (drop)      overflow <= 1'b1;
  end

`ifdef JTCPS1_FBWR_DROPCNT_EN
  always_ff @(posedge clk) begin
    if (!rstn)                              drop_cnt <= '0;
    else if (enter_act)                     drop_cnt <= '0;
    else if (drop && drop_cnt != 16'hFFFF)  drop_cnt <= drop_cnt + 16'd1;
  end
`endif

endmodule
